mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between the fetch stage (instruction reads) and the mem stage
//   (loads/stores). Fixed priority to the mem stage with a starvation guard for fetch. Sequences each

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_starve_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/mem-stage memory port arbiter: FSM states, winner ids
// and the fixed-priority winner rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_DM = 1'b1
  } win_t;

  // Mem stage wins unless fetch is also asking and has been passed over too often.
  function automatic win_t pick_winner(input logic if_req, input logic dm_req,
                                       input logic fetch_starved);
    return (dm_req && (!if_req || !fetch_starved)) ? WIN_DM : WIN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, mem-stage port, memory port and stall outputs.
// slave = the arbiter, master = requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              fetch_stall;
  logic              mem_stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, fetch_stall, mem_stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, fetch_stall, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Winner select for the shared port plus the saturating count of consecutive
// mem-stage grants taken while fetch was waiting.
module mem_port_arbiter_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant,
  output win_t winner
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_reg, starve_next;
  logic             fetch_starved;

  assign fetch_starved = (starve_reg >= CNT_W'(STARVE_MAX));
  assign winner        = pick_winner(if_req, dm_req, fetch_starved);

  // Only grants while fetch is pending count; any other grant restarts the run.
  always_comb begin
    starve_next = starve_reg;
    if (grant) begin
      if (winner == WIN_DM && if_req) begin
        if (!fetch_starved) starve_next = starve_reg + CNT_W'(1);
      end else begin
        starve_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_reg <= '0;
    else        starve_reg <= starve_next;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by fetch and mem stage: one access in flight,
// sequenced IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (ack) -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int K_W  = $clog2(WAIT_CYCLES + 1);

  state_t            state_reg, state_next;
  logic [K_W-1:0]    k_reg, k_next;
  win_t              win_reg, win_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [BE_W-1:0]   be_reg, be_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              mem_en_reg, mem_en_next;
  logic              if_ack_reg, if_ack_next;
  logic              dm_ack_reg, dm_ack_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;

  win_t            arb_win;
  logic            grant;
  logic [BE_W-1:0] lane_be;

  assign grant = (state_reg == ST_IDLE) && (bus.if_req || bus.dm_req);

  mem_port_arbiter_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .grant  (grant),
    .winner (arb_win)
  );

  // Loads read whole words, so only stores pass their byte enables through.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane_be
    assign lane_be[gi] = ~bus.dm_we | bus.dm_be[gi];
  end

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    win_next      = win_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    be_next       = be_reg;
    wdata_next    = wdata_reg;
    mem_en_next   = 1'b0;
    if_ack_next   = 1'b0;
    dm_ack_next   = 1'b0;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          state_next  = ST_ACCESS;
          k_next      = '0;
          win_next    = arb_win;
          mem_en_next = 1'b1;
          if (arb_win == WIN_DM) begin
            addr_next  = bus.dm_addr;
            we_next    = bus.dm_we;
            be_next    = lane_be;
            wdata_next = bus.dm_wdata;
          end else begin
            addr_next = bus.if_addr;
            we_next   = 1'b0;
            be_next   = '1;
          end
        end
      end
      ST_ACCESS: begin
        if (k_reg == K_W'(WAIT_CYCLES)) begin
          state_next = ST_RESP;
          if (win_reg == WIN_IF) begin
            if_rdata_next = bus.mem_rdata;
            if_ack_next   = 1'b1;
          end else begin
            if (!we_reg) dm_rdata_next = bus.mem_rdata;
            dm_ack_next = 1'b1;
          end
        end else begin
          k_next = k_reg + K_W'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      win_reg      <= WIN_IF;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      mem_en_reg   <= 1'b0;
      if_ack_reg   <= 1'b0;
      dm_ack_reg   <= 1'b0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      win_reg      <= win_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      be_reg       <= be_next;
      wdata_reg    <= wdata_next;
      mem_en_reg   <= mem_en_next;
      if_ack_reg   <= if_ack_next;
      dm_ack_reg   <= dm_ack_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  assign bus.mem_en      = mem_en_reg;
  assign bus.mem_we      = mem_en_reg & we_reg;
  assign bus.mem_be      = be_reg;
  assign bus.mem_addr    = addr_reg;
  assign bus.mem_wdata   = wdata_reg;
  assign bus.if_ack      = if_ack_reg;
  assign bus.dm_ack      = dm_ack_reg;
  assign bus.if_rdata    = if_rdata_reg;
  assign bus.dm_rdata    = dm_rdata_reg;
  assign bus.fetch_stall = bus.if_req & ~if_ack_reg;
  assign bus.mem_stall   = bus.dm_req & ~dm_ack_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level timing model checks the
// WAIT_CYCLES=1 instance every cycle; literal checks pin key cycles, incl. a WAIT_CYCLES=3 instance.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W  = 1;
  localparam int SM = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .STARVE_MAX(SM)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model of the W=1 instance ----------------
  int          g_t;        // cycle the current access was granted
  int          free_t;     // first cycle the arbiter can grant again
  int          starve_m;
  bit          g_dm;
  bit          g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_be;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  initial begin
    g_t = -100; free_t = 0; starve_m = 0; g_dm = 0; g_we = 0;
    g_addr = '0; g_wdata = '0; g_be = '0; exp_if_rdata = '0; exp_dm_rdata = '0;
  end

  always @(negedge clk) begin
    bit e_en, e_ifack, e_dmack;
    if (!rst_n) begin
      chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_if_ack", {31'd0, bus.if_ack}, 32'd0);
      chk("rst_dm_ack", {31'd0, bus.dm_ack}, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      g_t = -100; free_t = cyc + 1; starve_m = 0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
    end else begin
      e_en    = (cyc == g_t + 1);
      e_ifack = !g_dm && (cyc == g_t + W + 2);
      e_dmack =  g_dm && (cyc == g_t + W + 2);
      chk("mem_en", {31'd0, bus.mem_en}, {31'd0, e_en});
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e_en && g_we});
      chk("if_ack", {31'd0, bus.if_ack}, {31'd0, e_ifack});
      chk("dm_ack", {31'd0, bus.dm_ack}, {31'd0, e_dmack});
      chk("fetch_stall", {31'd0, bus.fetch_stall}, {31'd0, bus.if_req && !e_ifack});
      chk("mem_stall", {31'd0, bus.mem_stall}, {31'd0, bus.dm_req && !e_dmack});
      chk("if_rdata", bus.if_rdata, exp_if_rdata);
      chk("dm_rdata", bus.dm_rdata, exp_dm_rdata);
      if (cyc >= g_t + 1 && cyc <= g_t + 1 + W) begin
        chk("mem_addr", bus.mem_addr, g_addr);
        chk("mem_be", {28'd0, bus.mem_be}, {28'd0, g_be});
        if (g_we) chk("mem_wdata", bus.mem_wdata, g_wdata);
      end
      if (cyc == g_t + 1 + W) begin
        if (!g_dm)     exp_if_rdata = bus.mem_rdata;
        else if (!g_we) exp_dm_rdata = bus.mem_rdata;
      end
      if (cyc >= free_t && (bus.if_req || bus.dm_req)) begin
        g_dm     = bus.dm_req && (!bus.if_req || starve_m < SM);
        starve_m = (g_dm && bus.if_req) ? ((starve_m < SM) ? starve_m + 1 : SM) : 0;
        g_t      = cyc;
        free_t   = cyc + W + 3;
        g_we     = g_dm && bus.dm_we;
        g_addr   = g_dm ? bus.dm_addr : bus.if_addr;
        g_be     = (g_dm && bus.dm_we) ? bus.dm_be : 4'hF;
        g_wdata  = bus.dm_wdata;
        $display("grant cycle %0d to %s addr %h we %0d", cyc, g_dm ? "dm" : "if", g_addr, g_we);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int c);
    drive_at(c);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  int t0;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = '0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
    bus3.if_req = 0; bus3.if_addr = '0; bus3.dm_req = 0; bus3.dm_we = 0; bus3.dm_be = '0;
    bus3.dm_addr = '0; bus3.dm_wdata = '0; bus3.mem_rdata = '0;
    #2 rst_n = 1'b0;

    // Reset, then a single fetch
    at(3);
    chk("lit_rst_if_ack", {31'd0, bus.if_ack}, 32'd0);
    t0 = 4;
    drive_at(t0);
    rst_n = 1'b1; bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_rdata = 32'hDEADBEEF;
    at(t0);     chk("lit_f_stall0", {31'd0, bus.fetch_stall}, 32'd1);
                chk("lit_f_en0", {31'd0, bus.mem_en}, 32'd0);
    at(t0 + 1); chk("lit_f_en1", {31'd0, bus.mem_en}, 32'd1);
                chk("lit_f_addr1", bus.mem_addr, 32'h40);
    at(t0 + 2); chk("lit_f_en2", {31'd0, bus.mem_en}, 32'd0);
                chk("lit_f_stall2", {31'd0, bus.fetch_stall}, 32'd1);
    at(t0 + 3); chk("lit_f_ack3", {31'd0, bus.if_ack}, 32'd1);
                chk("lit_f_stall3", {31'd0, bus.fetch_stall}, 32'd0);
    drive_at(t0 + 4); bus.if_req = 0;
    at(t0 + 4); chk("lit_f_ack4", {31'd0, bus.if_ack}, 32'd0);
                chk("lit_f_rdata", bus.if_rdata, 32'hDEADBEEF);

    // Simultaneous fetch and load: load first, fetch right after
    t0 = cyc + 2;
    drive_at(t0);
    bus.if_req = 1; bus.if_addr = 32'h80;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100; bus.mem_rdata = 32'hA5A50100;
    at(t0 + 1); chk("lit_c_addr1", bus.mem_addr, 32'h100);
    at(t0 + 3); chk("lit_c_dmack3", {31'd0, bus.dm_ack}, 32'd1);
                chk("lit_c_ifack3", {31'd0, bus.if_ack}, 32'd0);
    drive_at(t0 + 4); bus.dm_req = 0; bus.mem_rdata = 32'h0BADF00D;
    at(t0 + 4); chk("lit_c_dmrdata", bus.dm_rdata, 32'hA5A50100);
    at(t0 + 5); chk("lit_c_en5", {31'd0, bus.mem_en}, 32'd1);
                chk("lit_c_addr5", bus.mem_addr, 32'h80);
    at(t0 + 7); chk("lit_c_ifack7", {31'd0, bus.if_ack}, 32'd1);
    drive_at(t0 + 8); bus.if_req = 0;
    at(t0 + 8); chk("lit_c_ifrdata", bus.if_rdata, 32'h0BADF00D);

    // Partial store
    t0 = cyc + 2;
    drive_at(t0);
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'b0011; bus.dm_addr = 32'h200;
    bus.dm_wdata = 32'h12345678; bus.mem_rdata = 32'hFFFFFFFF;
    at(t0 + 1); chk("lit_s_we1", {31'd0, bus.mem_we}, 32'd1);
                chk("lit_s_be1", {28'd0, bus.mem_be}, 32'h3);
                chk("lit_s_wdata1", bus.mem_wdata, 32'h12345678);
    at(t0 + 2); chk("lit_s_we2", {31'd0, bus.mem_we}, 32'd0);
    at(t0 + 3); chk("lit_s_ack3", {31'd0, bus.dm_ack}, 32'd1);
    drive_at(t0 + 4); bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = '0;
    at(t0 + 4); chk("lit_s_dmrdata", bus.dm_rdata, 32'hA5A50100);

    // Both held: dm,dm,dm,dm,if,dm
    t0 = cyc + 2;
    drive_at(t0);
    bus.if_req = 1; bus.if_addr = 32'h44;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300; bus.mem_rdata = 32'h11112222;
    for (int k = 0; k < 6; k++) begin
      at(t0 + 1 + 4 * k);
      chk($sformatf("lit_h_addr%0d", k), bus.mem_addr, (k == 4) ? 32'h44 : 32'h300);
      at(t0 + 3 + 4 * k);
      chk($sformatf("lit_h_ifack%0d", k), {31'd0, bus.if_ack}, (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("lit_h_dmack%0d", k), {31'd0, bus.dm_ack}, (k == 4) ? 32'd0 : 32'd1);
    end
    drive_at(t0 + 24); bus.if_req = 0; bus.dm_req = 0;

    // Reset during ACCESS abandons the store; reissue completes normally
    t0 = cyc + 2;
    drive_at(t0);
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'hF; bus.dm_addr = 32'h400;
    bus.dm_wdata = 32'hCAFEF00D;
    drive_at(t0 + 1);
    chk("lit_r_en_pre", {31'd0, bus.mem_en}, 32'd1);
    chk("lit_r_we_pre", {31'd0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("lit_r_en_post", {31'd0, bus.mem_en}, 32'd0);
    chk("lit_r_we_post", {31'd0, bus.mem_we}, 32'd0);
    at(t0 + 2); chk("lit_r_noack", {31'd0, bus.dm_ack}, 32'd0);
    drive_at(t0 + 3); rst_n = 1'b1;
    at(t0 + 4); chk("lit_r_en_re", {31'd0, bus.mem_en}, 32'd1);
                chk("lit_r_addr_re", bus.mem_addr, 32'h400);
    at(t0 + 6); chk("lit_r_ack_re", {31'd0, bus.dm_ack}, 32'd1);
    drive_at(t0 + 7); bus.dm_req = 0; bus.dm_we = 0;

    // WAIT_CYCLES=3 instance: fetch timing
    t0 = cyc + 2;
    drive_at(t0);
    bus3.if_req = 1; bus3.if_addr = 32'h80; bus3.mem_rdata = 32'h0;
    at(t0 + 1); chk("lit_w3_en1", {31'd0, bus3.mem_en}, 32'd1);
    at(t0 + 2); chk("lit_w3_en2", {31'd0, bus3.mem_en}, 32'd0);
    drive_at(t0 + 4); bus3.mem_rdata = 32'h600DCAFE;
    at(t0 + 4); chk("lit_w3_ack4", {31'd0, bus3.if_ack}, 32'd0);
    drive_at(t0 + 5); bus3.mem_rdata = 32'hBAD00000;
    at(t0 + 5); chk("lit_w3_ack5", {31'd0, bus3.if_ack}, 32'd1);
                chk("lit_w3_rdata", bus3.if_rdata, 32'h600DCAFE);
    drive_at(t0 + 6); bus3.if_req = 0;
    at(t0 + 6); chk("lit_w3_ack6", {31'd0, bus3.if_ack}, 32'd0);

    at(cyc + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
